// File: rtl/mos_pkg.sv
// Shared definitions for the MOS host: data widths, matrix size limits,
// FSM state encoding and small size-dependent helpers.
package mos_pkg;

  localparam int DATA_W   = 16;
  localparam int ACC_W    = 40;
  localparam int N_SMALL  = 4;
  localparam int N_LARGE  = 8;
  localparam int MAX_ELEM = 64;
  localparam int MAX_RES  = 15;

  typedef enum logic [2:0] {IDLE, SEND, WAIT, RECV, DONE} state_t;

  // Number of beats sent per transaction: both matrices, N*N elements each.
  function automatic logic [7:0] beat_total(input logic size);
    return size ? 8'(2 * N_LARGE * N_LARGE) : 8'(2 * N_SMALL * N_SMALL);
  endfunction

  // Number of anti-diagonal sums expected back: 2N-1.
  function automatic logic [4:0] res_total(input logic size);
    return size ? 5'(2 * N_LARGE - 1) : 5'(2 * N_SMALL - 1);
  endfunction

endpackage

// File: rtl/mos_host.sv
// mos_host: host/initiator for a matrix-output-sum engine. Holds one weight
// and one input matrix, streams them out row-major, then captures the 2N-1
// anti-diagonal sums the engine returns.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   ld_en/ld_sel/ld_addr/ld_data    matrix load bus (sel 0 = weight, 1 = input)
//   cfg_size, start                 size select (0 = 4x4, 1 = 8x8) and kick-off
//   busy, done                      transaction in flight / 1-cycle end pulse
//   err_timeout, err_len, err_proto sticky error flags, cleared on start
//   rd_addr, rd_data                result readback, 1-cycle latency
//   mos_*                           stream interface to the engine
//
// state | meaning
// IDLE  | waiting for start; loads accepted
// SEND  | streaming 2*N*N matrix beats
// WAIT  | waiting for first response beat, timeout running
// RECV  | capturing response beats
// DONE  | one-cycle done pulse, back to IDLE
module mos_host
  import mos_pkg::*;
#(
  parameter int TIMEOUT = 200
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ld_en,
  input  logic                     ld_sel,
  input  logic [5:0]               ld_addr,
  input  logic signed [DATA_W-1:0] ld_data,
  input  logic                     cfg_size,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     err_timeout,
  output logic                     err_len,
  output logic                     err_proto,
  input  logic [3:0]               rd_addr,
  output logic signed [ACC_W-1:0]  rd_data,
  output logic                     mos_matrix_size,
  output logic                     mos_in_valid,
  output logic signed [DATA_W-1:0] mos_in_data,
  input  logic                     mos_out_valid,
  input  logic signed [ACC_W-1:0]  mos_out_data
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);

  state_t            state_q, state_d;
  logic              size_q, size_d;
  logic [7:0]        beat_q, beat_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [4:0]        rcnt_q, rcnt_d;
  logic              in_valid_d, msize_d;
  logic signed [DATA_W-1:0] in_data_d;
  logic              err_timeout_d, err_len_d, err_proto_d;
  logic              res_we, res_clr;
  logic [3:0]        res_idx;

  logic signed [DATA_W-1:0] w_mem [MAX_ELEM];
  logic signed [DATA_W-1:0] x_mem [MAX_ELEM];
  // One spare slot so any 4-bit rd_addr stays inside the array.
  logic signed [ACC_W-1:0]  res_mem [MAX_RES+1];

  logic [5:0]               b_idx;
  logic                     b_sel;
  logic signed [DATA_W-1:0] beat_word, first_word;

  assign busy = (state_q == SEND) || (state_q == WAIT) || (state_q == RECV);
  assign done = (state_q == DONE);

  // Beat b addresses weight[b] for b < N*N, otherwise input[b-N*N]; with N*N
  // a power of two that is just a bit select.
  assign b_idx     = size_q ? beat_q[5:0] : {2'b00, beat_q[3:0]};
  assign b_sel     = size_q ? beat_q[6] : beat_q[4];
  assign beat_word = b_sel ? x_mem[b_idx] : w_mem[b_idx];
  // A weight[0] load in the start cycle must reach beat 0.
  assign first_word = (ld_en && !ld_sel && ld_addr == 6'd0) ? ld_data : w_mem[0];

  always_comb begin
    state_d       = state_q;
    size_d        = size_q;
    beat_d        = beat_q;
    tmr_d         = tmr_q;
    rcnt_d        = rcnt_q;
    in_valid_d    = 1'b0;
    in_data_d     = '0;
    msize_d       = 1'b0;
    err_timeout_d = err_timeout;
    err_len_d     = err_len;
    err_proto_d   = err_proto;
    res_we        = 1'b0;
    res_clr       = 1'b0;
    res_idx       = rcnt_q[3:0];

    if (mos_out_valid && (state_q == IDLE || state_q == SEND || state_q == DONE))
      err_proto_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d       = SEND;
          size_d        = cfg_size;
          err_timeout_d = 1'b0;
          err_len_d     = 1'b0;
          err_proto_d   = mos_out_valid;
          res_clr       = 1'b1;
          in_valid_d    = 1'b1;
          in_data_d     = first_word;
          msize_d       = cfg_size;
          beat_d        = 8'd1;
        end
      end
      SEND: begin
        if (beat_q == beat_total(size_q)) begin
          state_d = WAIT;
          tmr_d   = TMR_W'(TIMEOUT - 1);
        end else begin
          in_valid_d = 1'b1;
          in_data_d  = beat_word;
          beat_d     = beat_q + 8'd1;
        end
      end
      WAIT: begin
        if (mos_out_valid) begin
          state_d = RECV;
          res_we  = 1'b1;
          res_idx = 4'd0;
          rcnt_d  = 5'd1;
        end else if (tmr_q == '0) begin
          state_d       = DONE;
          err_timeout_d = 1'b1;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      RECV: begin
        if (mos_out_valid) begin
          if (rcnt_q < res_total(size_q)) res_we = 1'b1;
          else                            err_len_d = 1'b1;
          if (rcnt_q != 5'd31) rcnt_d = rcnt_q + 5'd1;
        end else begin
          if (rcnt_q != res_total(size_q)) err_len_d = 1'b1;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      size_q          <= 1'b0;
      beat_q          <= '0;
      tmr_q           <= '0;
      rcnt_q          <= '0;
      mos_in_valid    <= 1'b0;
      mos_in_data     <= '0;
      mos_matrix_size <= 1'b0;
      err_timeout     <= 1'b0;
      err_len         <= 1'b0;
      err_proto       <= 1'b0;
    end else begin
      state_q         <= state_d;
      size_q          <= size_d;
      beat_q          <= beat_d;
      tmr_q           <= tmr_d;
      rcnt_q          <= rcnt_d;
      mos_in_valid    <= in_valid_d;
      mos_in_data     <= in_data_d;
      mos_matrix_size <= msize_d;
      err_timeout     <= err_timeout_d;
      err_len         <= err_len_d;
      err_proto       <= err_proto_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ld_en && !busy) begin
      if (ld_sel) x_mem[ld_addr] <= ld_data;
      else        w_mem[ld_addr] <= ld_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_RES + 1; i++) res_mem[i] <= '0;
    end else if (res_clr) begin
      for (int i = 0; i < MAX_RES + 1; i++) res_mem[i] <= '0;
    end else if (res_we) begin
      res_mem[res_idx] <= mos_out_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                    rd_data <= '0;
    else if ({1'b0, rd_addr} < res_total(size_q))  rd_data <= res_mem[rd_addr];
    else                                           rd_data <= '0;
  end

endmodule

// File: tb/tb_mos_host.sv
// Scoreboard bench for mos_host: expected beats, done flags and readback
// values are queued when stimulus is issued and popped by monitors.
module tb_mos_host;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               ld_en, ld_sel, cfg_size, start;
  logic [5:0]         ld_addr;
  logic signed [15:0] ld_data;
  logic               busy, done, err_timeout, err_len, err_proto;
  logic [3:0]         rd_addr;
  logic signed [39:0] rd_data;
  logic               mos_matrix_size, mos_in_valid, mos_out_valid;
  logic signed [15:0] mos_in_data;
  logic signed [39:0] mos_out_data;

  mos_host #(.TIMEOUT(200)) dut (
    .clk(clk), .rst_n(rst_n),
    .ld_en(ld_en), .ld_sel(ld_sel), .ld_addr(ld_addr), .ld_data(ld_data),
    .cfg_size(cfg_size), .start(start),
    .busy(busy), .done(done),
    .err_timeout(err_timeout), .err_len(err_len), .err_proto(err_proto),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .mos_matrix_size(mos_matrix_size), .mos_in_valid(mos_in_valid),
    .mos_in_data(mos_in_data),
    .mos_out_valid(mos_out_valid), .mos_out_data(mos_out_data)
  );

  always #5 clk = ~clk;

  typedef struct { logic signed [15:0] data; logic msize; } beat_t;
  typedef struct { logic t; logic l; logic p; } flags_t;

  beat_t              exp_beat[$];
  flags_t             exp_done[$];
  logic signed [39:0] exp_rd[$];
  logic signed [39:0] resp_q[$];

  logic signed [15:0] w_ref [64];
  logic signed [15:0] x_ref [64];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_beat_cyc = 0;
  int   done_cyc = 0;
  logic rd_req = 1'b0;
  logic rd_vld = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    rd_vld <= rd_req;
  end

  // Beat monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (mos_in_valid) begin
        last_beat_cyc = cyc;
        if (exp_beat.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected actual=%0h required=none", mos_in_data);
        end else begin
          beat_t e;
          e = exp_beat.pop_front();
          chk("beat_data", mos_in_data, e.data);
          chk("beat_msize", mos_matrix_size, e.msize);
        end
      end else begin
        chk("idle_in_data", mos_in_data, 0);
        chk("idle_msize", mos_matrix_size, 0);
      end
    end
  end

  // Done monitor
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cyc = cyc;
      chk("done_busy", busy, 0);
      if (exp_done.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected actual=1 required=0");
      end else begin
        flags_t f;
        f = exp_done.pop_front();
        chk("err_timeout", err_timeout, f.t);
        chk("err_len", err_len, f.l);
        chk("err_proto", err_proto, f.p);
      end
    end
  end

  // Readback monitor
  always @(negedge clk) begin
    if (rst_n && rd_vld) begin
      if (exp_rd.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected actual=%0h required=none", rd_data);
      end else begin
        chk("rd_data", rd_data, exp_rd.pop_front());
      end
    end
  end

  task automatic ld(input logic sel, input int a, input logic signed [15:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_sel = sel; ld_addr = 6'(a); ld_data = d;
    if (sel) x_ref[a] = d; else w_ref[a] = d;
    @(posedge clk); #1 ld_en = 1'b0;
  endtask

  task automatic push_beats(input logic sz);
    int nn;
    beat_t e;
    nn = sz ? 64 : 16;
    for (int b = 0; b < 2 * nn; b++) begin
      e.data  = (b < nn) ? w_ref[b] : x_ref[b - nn];
      e.msize = (b == 0) ? sz : 1'b0;
      exp_beat.push_back(e);
    end
  endtask

  task automatic push_done(input logic t, input logic l, input logic p);
    flags_t f;
    f.t = t; f.l = l; f.p = p;
    exp_done.push_back(f);
  endtask

  task automatic go(input logic sz);
    @(negedge clk);
    start = 1'b1; cfg_size = sz;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_send_end(input string nm);
    bit saw, fin;
    saw = 0; fin = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (mos_in_valid) saw = 1;
      else if (saw) begin fin = 1; break; end
    end
    chk({nm, "_send_end"}, fin, 1);
    chk({nm, "_beats_left"}, exp_beat.size(), 0);
  endtask

  task automatic respond();
    repeat (2) @(negedge clk);
    while (resp_q.size() > 0) begin
      mos_out_valid = 1'b1;
      mos_out_data  = resp_q.pop_front();
      @(negedge clk);
    end
    mos_out_valid = 1'b0;
    mos_out_data  = '0;
  endtask

  task automatic wait_done(input string nm);
    bit seen;
    seen = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done) begin seen = 1; break; end
    end
    #1 chk({nm, "_done_seen"}, seen, 1);
  endtask

  task automatic rd_chk(input int a, input logic signed [39:0] e);
    @(negedge clk);
    rd_addr = 4'(a); rd_req = 1'b1;
    exp_rd.push_back(e);
    @(posedge clk); #1 rd_req = 1'b0;
  endtask

  function automatic logic signed [39:0] tri4(input int k);
    return 40'(k < 4 ? k + 1 : 7 - k);
  endfunction

  initial begin
    rst_n = 1'b0; ld_en = 0; ld_sel = 0; ld_addr = 0; ld_data = 0;
    cfg_size = 0; start = 0; rd_addr = 0; mos_out_valid = 0; mos_out_data = 0;
    for (int i = 0; i < 64; i++) begin w_ref[i] = 0; x_ref[i] = 0; end
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_in_valid", mos_in_valid, 0);
    chk("rst_in_data", mos_in_data, 0);
    chk("rst_errs", {err_timeout, err_len, err_proto}, 0);
    chk("rst_rd_data", rd_data, 0);
    rst_n = 1'b1;
    rd_chk(0, 0);

    // 4x4 identity x ones; weight[0] rewritten in the start cycle
    ld(0, 0, 16'sd5);
    for (int i = 1; i < 16; i++) ld(0, i, (i % 5 == 0) ? 16'sd1 : 16'sd0);
    for (int i = 0; i < 16; i++) ld(1, i, 16'sd1);
    w_ref[0] = 16'sd1;
    push_beats(0);
    push_done(0, 0, 0);
    @(negedge clk);
    start = 1; cfg_size = 0; ld_en = 1; ld_sel = 0; ld_addr = 0; ld_data = 16'sd1;
    @(negedge clk);
    start = 0; ld_en = 0;
    chk("t1_busy", busy, 1);
    wait_send_end("t1");
    for (int k = 0; k < 7; k++) resp_q.push_back(tri4(k));
    respond();
    wait_done("t1");
    for (int k = 0; k < 7; k++) rd_chk(k, tri4(k));
    rd_chk(7, 0);
    rd_chk(15, 0);

    // 8x8 W all 2, X all -1
    for (int i = 0; i < 64; i++) ld(0, i, 16'sd2);
    for (int i = 0; i < 64; i++) ld(1, i, -16'sd1);
    push_beats(1);
    push_done(0, 0, 0);
    go(1);
    wait_send_end("t2");
    for (int k = 0; k < 15; k++) resp_q.push_back(-40'sd16 * 40'(k < 8 ? k + 1 : 15 - k));
    respond();
    wait_done("t2");
    for (int k = 0; k < 15; k++) rd_chk(k, -40'sd16 * 40'(k < 8 ? k + 1 : 15 - k));
    rd_chk(15, 0);

    // No response: timeout
    push_beats(0);
    push_done(1, 0, 0);
    go(0);
    wait_send_end("t3");
    wait_done("t3");
    chk("t3_timeout_gap", done_cyc - last_beat_cyc, 201);
    rd_chk(0, 0);

    // Short response: 5 beats
    push_beats(0);
    push_done(0, 1, 0);
    go(0);
    chk("t4_timeout_cleared", err_timeout, 0);
    wait_send_end("t4");
    for (int k = 0; k < 5; k++) resp_q.push_back(40'sd10 * 40'(k + 1));
    respond();
    wait_done("t4");
    for (int k = 0; k < 5; k++) rd_chk(k, 40'sd10 * 40'(k + 1));
    rd_chk(5, 0);
    rd_chk(6, 0);

    // Long response: 9 beats, only first 7 kept
    push_beats(0);
    push_done(0, 1, 0);
    go(0);
    wait_send_end("t5");
    for (int k = 0; k < 9; k++) resp_q.push_back(-40'sd101 - 40'(k));
    respond();
    wait_done("t5");
    for (int k = 0; k < 7; k++) rd_chk(k, -40'sd101 - 40'(k));
    rd_chk(7, 0);

    // start/ld_en/out_valid while sending
    push_beats(0);
    push_done(0, 0, 1);
    go(0);
    repeat (3) @(negedge clk);
    start = 1; cfg_size = 1; ld_en = 1; ld_sel = 1; ld_addr = 6'd15; ld_data = 16'sd777;
    mos_out_valid = 1; mos_out_data = 40'sd999;
    @(negedge clk);
    start = 0; cfg_size = 0; ld_en = 0; mos_out_valid = 0; mos_out_data = 0;
    wait_send_end("t6");
    for (int k = 0; k < 7; k++) resp_q.push_back(tri4(k));
    respond();
    wait_done("t6");
    rd_chk(3, 4);

    // Async reset at beat 10
    push_beats(0);
    go(0);
    repeat (10) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("t7_in_valid", mos_in_valid, 0);
    chk("t7_busy", busy, 0);
    chk("t7_done", done, 0);
    exp_beat.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("t7_errs", {err_timeout, err_len, err_proto}, 0);

    // Fresh run after reset
    push_beats(0);
    push_done(0, 0, 0);
    go(0);
    wait_send_end("t8");
    for (int k = 0; k < 7; k++) resp_q.push_back(tri4(k) + 40'sd1000);
    respond();
    wait_done("t8");
    for (int k = 0; k < 7; k++) rd_chk(k, tri4(k) + 40'sd1000);

    repeat (5) @(negedge clk);
    chk("end_done_q", exp_done.size(), 0);
    chk("end_rd_q", exp_rd.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
